// File: rtl/bmp_stream_parser.sv
// Parses a 24-bit uncompressed BMP byte stream into header fields and {R,G,B}
// pixels tagged with file row/column and linear address.
module bmp_stream_parser #(
  parameter int MAX_W  = 640,
  parameter int MAX_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Frame_Start,
  input  logic [7:0]        Byte_In,
  input  logic              Byte_Valid,
  output logic [15:0]       Img_Width,
  output logic [15:0]       Img_Height,
  output logic              Hdr_Valid,
  output logic [23:0]       Pix_Data,
  output logic [15:0]       Pix_Row,
  output logic [15:0]       Pix_Col,
  output logic [ADDR_W-1:0] Pix_Addr,
  output logic              Pix_Valid,
  output logic              Frame_Done,
  output logic              Err,
  output logic [1:0]        Err_Code,
  output logic [2:0]        Dbg_State
);

  // Byte_Valid is a one-cycle strobe with no back-pressure: every strobe is
  // consumed in the cycle it arrives, so consecutive strobes are all taken.
  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_SKIP, S_PIXEL, S_PAD, S_DONE, S_ERROR
  } state_t;

  state_t r_state, w_st, w_next;

  logic [15:0]       r_byte_idx, r_offset, r_col, r_row;
  logic [7:0]        r_bpp_lo, r_b, r_g;
  logic [1:0]        r_lane, r_pad_cnt;
  logic [ADDR_W-1:0] r_addr;

  logic [15:0] w_idx;
  logic [1:0]  w_err_code;
  logic        w_hdr_byte, w_pix_byte, w_pad_byte, w_accept;
  logic        w_emit, w_row_end, w_last_row, w_err, w_hdr_ok, w_dim_bad;

  assign Dbg_State = r_state;

  // Frame_Start behaves as if the parser were already in HEADER at byte 0, so a
  // coincident byte is parsed as the first byte of the new file.
  always_comb begin
    w_st       = Frame_Start ? S_HEADER : r_state;
    w_idx      = Frame_Start ? 16'd0 : r_byte_idx;
    w_hdr_byte = Byte_Valid && (w_st == S_HEADER);
    w_pix_byte = Byte_Valid && ((w_st == S_PIXEL) ||
                                ((w_st == S_SKIP) && (w_idx == r_offset)));
    w_pad_byte = Byte_Valid && (w_st == S_PAD);
    w_accept   = Byte_Valid && ((w_st == S_HEADER) || (w_st == S_SKIP) ||
                                (w_st == S_PIXEL) || (w_st == S_PAD));
    w_emit     = w_pix_byte && (r_lane == 2'd2);
    w_row_end  = w_emit && (r_col == Img_Width - 16'd1);
    w_last_row = (r_row == Img_Height - 16'd1);
    w_dim_bad  = (Img_Width == 16'd0) || (Img_Width > 16'(MAX_W)) ||
                 (Img_Height == 16'd0) || (Img_Height > 16'(MAX_H)) ||
                 (r_offset < 16'd54);

    w_err_code = 2'd0;
    if (w_hdr_byte) begin
      case (w_idx)
        16'd0:  if (Byte_In != 8'h42) w_err_code = 2'd1;
        16'd1:  if (Byte_In != 8'h4D) w_err_code = 2'd1;
        16'd12, 16'd13, 16'd20, 16'd21, 16'd24, 16'd25:
                if (Byte_In != 8'h00) w_err_code = 2'd3;
        16'd29: if ({Byte_In, r_bpp_lo} != 16'd24) w_err_code = 2'd2;
                else if (w_dim_bad)                w_err_code = 2'd3;
        default: ;
      endcase
    end
    w_err    = (w_err_code != 2'd0);
    w_hdr_ok = w_hdr_byte && (w_idx == 16'd29) && !w_err;

    w_next = w_st;
    case (w_st)
      S_HEADER: if (w_err) w_next = S_ERROR;
                else if (w_hdr_ok) w_next = S_SKIP;
      S_SKIP:   if (w_pix_byte) w_next = S_PIXEL;
      S_PIXEL:  if (w_row_end) begin
                  if (Img_Width[1:0] != 2'd0) w_next = S_PAD;
                  else if (w_last_row)        w_next = S_DONE;
                end
      // Row has already advanced when padding is consumed.
      S_PAD:    if (w_pad_byte && (r_pad_cnt == 2'd1))
                  w_next = (r_row == Img_Height) ? S_DONE : S_PIXEL;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_byte_idx <= '0; r_offset <= '0; r_col <= '0; r_row <= '0;
      r_bpp_lo   <= '0; r_b <= '0; r_g <= '0; r_lane <= '0; r_pad_cnt <= '0;
      r_addr     <= '0;
      Img_Width  <= '0; Img_Height <= '0; Hdr_Valid <= 1'b0;
      Pix_Data   <= '0; Pix_Row <= '0; Pix_Col <= '0; Pix_Addr <= '0;
      Pix_Valid  <= 1'b0; Frame_Done <= 1'b0; Err <= 1'b0; Err_Code <= '0;
    end else begin
      Pix_Valid  <= 1'b0;
      Frame_Done <= (w_next == S_DONE);
      if (Frame_Start) begin
        r_byte_idx <= '0; r_offset <= '0; r_col <= '0; r_row <= '0;
        r_bpp_lo   <= '0; r_lane <= '0; r_pad_cnt <= '0; r_addr <= '0;
        Img_Width  <= '0; Img_Height <= '0; Hdr_Valid <= 1'b0;
        Err        <= 1'b0; Err_Code <= '0;
      end
      if (w_accept) r_byte_idx <= w_idx + 16'd1;
      if (w_hdr_byte) begin
        case (w_idx)
          16'd10: r_offset[7:0]    <= Byte_In;
          16'd11: r_offset[15:8]   <= Byte_In;
          16'd18: Img_Width[7:0]   <= Byte_In;
          16'd19: Img_Width[15:8]  <= Byte_In;
          16'd22: Img_Height[7:0]  <= Byte_In;
          16'd23: Img_Height[15:8] <= Byte_In;
          16'd28: r_bpp_lo         <= Byte_In;
          default: ;
        endcase
      end
      if (w_err) begin
        Err      <= 1'b1;
        Err_Code <= w_err_code;
      end
      if (w_hdr_ok) Hdr_Valid <= 1'b1;
      if (w_pix_byte) begin
        case (r_lane)
          2'd0: begin r_b <= Byte_In; r_lane <= 2'd1; end
          2'd1: begin r_g <= Byte_In; r_lane <= 2'd2; end
          default: begin
            Pix_Valid <= 1'b1;
            Pix_Data  <= {Byte_In, r_g, r_b};
            Pix_Row   <= r_row;
            Pix_Col   <= r_col;
            Pix_Addr  <= r_addr;
            r_addr    <= r_addr + ADDR_W'(1);
            r_lane    <= 2'd0;
            if (w_row_end) begin
              r_col     <= '0;
              r_row     <= r_row + 16'd1;
              r_pad_cnt <= Img_Width[1:0];
            end else begin
              r_col <= r_col + 16'd1;
            end
          end
        endcase
      end
      if (w_pad_byte) r_pad_cnt <= r_pad_cnt - 2'd1;
    end
  end

endmodule
